// File: rtl/matmul_result_collector.sv
`default_nettype none
// ============================================================================
// matmul_result_collector: rebuilds 2x2 C results from the array's two-beat
// nibble bursts, buffers them in a 2-entry FIFO and streams them out by byte.
// Revision: 1.0
// ============================================================================
module matmul_result_collector (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] res_lo,
    input  logic [7:0] res_hi,
    input  logic [7:0] res_oe,
    output logic [7:0] m_data,
    output logic [1:0] m_idx,
    output logic       m_last,
    output logic       m_valid,
    input  logic       m_ready,
    input  logic       clr,
    output logic       overflow,
    output logic       frame_err,
    output logic [7:0] result_count
);

    typedef enum logic [0:0] {
        WAIT_ROW0 = 1'b0,
        WAIT_ROW1 = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_beat;
    logic [7:0]  w_x;
    logic [7:0]  w_y;
    logic        w_latch;
    logic        w_push;
    logic        w_frame_set;
    logic [7:0]  r_c00;
    logic [7:0]  r_c01;
    logic [31:0] w_result;

    logic [31:0] r_mem [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_level;
    logic [1:0]  r_elem;
    logic        w_full;
    logic        w_pop;
    logic        w_accept;
    logic        w_drop;
    logic [31:0] w_head;
    logic [7:0]  w_sel;
    logic        r_overflow;
    logic        r_frame_err;
    logic [7:0]  r_count;

    // Only an all-ones output enable is a real beat; partial enables are ignored.
    assign w_beat   = (res_oe == 8'hFF);
    assign w_x      = {res_hi[7:4], res_lo[7:4]};
    assign w_y      = {res_hi[3:0], res_lo[3:0]};
    assign w_result = {r_c00, r_c01, w_x, w_y};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WAIT_ROW0;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_push       = 1'b0;
        w_frame_set  = 1'b0;
        case (r_state)
            WAIT_ROW0: begin
                if (w_beat) begin
                    w_latch      = 1'b1;
                    w_next_state = WAIT_ROW1;
                end
            end
            WAIT_ROW1: begin
                w_next_state = WAIT_ROW0;
                if (w_beat) begin
                    w_push = 1'b1;
                end else begin
                    w_frame_set = 1'b1;
                end
            end
            default: w_next_state = WAIT_ROW0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c00 <= 8'h00;
            r_c01 <= 8'h00;
        end else if (w_latch) begin
            r_c00 <= w_x;
            r_c01 <= w_y;
        end
    end

    // A full FIFO still takes a push when its head leaves on the same edge.
    assign w_full   = (r_level == 2'd2);
    assign w_pop    = m_valid && m_ready && (r_elem == 2'd3);
    assign w_accept = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= 32'h0;
            r_mem[1] <= 32'h0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_level  <= 2'd0;
            r_elem   <= 2'd0;
            r_count  <= 8'h00;
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= w_result;
                r_wr_ptr        <= ~r_wr_ptr;
                r_count         <= r_count + 8'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (m_valid && m_ready) begin
                r_elem <= r_elem + 2'd1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + 2'd1;
                2'b01:   r_level <= r_level - 2'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr) begin
                r_overflow <= 1'b0;
            end
            if (w_frame_set) begin
                r_frame_err <= 1'b1;
            end else if (clr) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        w_sel = 8'h00;
        case (r_elem)
            2'd0:    w_sel = w_head[31:24];
            2'd1:    w_sel = w_head[23:16];
            2'd2:    w_sel = w_head[15:8];
            default: w_sel = w_head[7:0];
        endcase
    end

    assign m_valid      = (r_level != 2'd0);
    assign m_data       = m_valid ? w_sel : 8'h00;
    assign m_idx        = r_elem;
    assign m_last       = (r_elem == 2'd3);
    assign overflow     = r_overflow;
    assign frame_err    = r_frame_err;
    assign result_count = r_count;

endmodule
`default_nettype wire

// File: doc/matmul_result_collector.md
# matmul_result_collector

Downstream stage of `tt_um_systolic_matmul`. It captures the two-beat result burst that the array drives on `uo_out`/`uio_out` while `uio_oe` is all-ones, and rebuilds the four 8-bit C elements from the interleaved nibbles. Completed results go into a 2-entry result FIFO, so the array, which has no backpressure, is never stalled. The FIFO drains as a byte stream over a valid/ready interface, with sticky overflow and framing-error status.

## Interface
Parameters:
- none. Widths are fixed by the 2x2, 8-bit-result array.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  rising-edge clock, shared with the array.
- `rst`  in  1  asynchronous reset, active-high.
- `res_lo`  in  8  array `uo_out`.
- `res_hi`  in  8  array `uio_out`.
- `res_oe`  in  8  array `uio_oe`. A beat is present only when it is exactly 8'hFF.
- `m_data`  out  8  current C element.
- `m_idx`  out  2  element index: 0=C00, 1=C01, 2=C10, 3=C11.
- `m_last`  out  1  high when `m_idx`==3.
- `m_valid`  out  1  element available.
- `m_ready`  in  1  consumer accepts the element.
- `clr`  in  1  synchronous clear of the sticky flags.
- `overflow`  out  1  sticky: a complete result was dropped because the FIFO was full.
- `frame_err`  out  1  sticky: a row-0 beat was not followed by a row-1 beat.
- `result_count`  out  8  results accepted into the FIFO, mod 256.

## Operation
Nibble unpacking, per beat:
- Element X = {`res_hi[7:4]`, `res_lo[7:4]`}.
- Element Y = {`res_hi[3:0]`, `res_lo[3:0]`}.
- Row-0 beat gives X=C00, Y=C01. Row-1 beat gives X=C10, Y=C11.

Capture FSM, states `WAIT_ROW0`, `WAIT_ROW1`:
- `WAIT_ROW0`, beat present: latch C00/C01 into staging, go to `WAIT_ROW1`. No beat: stay.
- `WAIT_ROW1`, beat present: form the 32-bit result {C00,C01,C10,C11} and push it. Go to `WAIT_ROW0`.
- `WAIT_ROW1`, no beat: set `frame_err`, discard staging, go to `WAIT_ROW0`.
- `res_oe` held high for 3 or more cycles: beats alternate row0/row1. The third beat starts a new result.
- Any `res_oe` value other than 8'hFF or 8'h00 counts as "no beat".

Push rules:
- FIFO not full: write the result, increment `result_count` (wraps 255→0).
- FIFO full and no pop this cycle: drop the result, set `overflow`, leave the count unchanged.
- FIFO full with a pop this cycle: the push is accepted (pop-then-push on the same edge).

Output serializer:
- `m_valid` = FIFO not empty.
- `m_data` = the head entry element selected by the internal element counter; `m_idx` = that counter.
- On `m_valid && m_ready`, the counter increments. When the counter is at 3, it wraps to 0 and the head is popped.
- While `m_valid` is high and `m_ready` is low, `m_data`, `m_idx` and `m_last` hold stable.

Flags:
- `overflow` and `frame_err` stay set until `clr` or `rst`.
- If `clr` and a new set event occur in the same cycle, set wins.

## Timing
- Reset values: `m_data`=0, `m_idx`=0, `m_last`=0, `m_valid`=0, `overflow`=0, `frame_err`=0, `result_count`=0. FIFO empty, FSM in `WAIT_ROW0`, element counter 0.
- Reset asserted mid-burst or mid-drain: staging and FIFO contents are lost. After deassertion, the first beat is treated as row 0.
- Latency: the row-1 beat is sampled at edge E. `m_valid` rises in the cycle after E when the FIFO was empty, with `m_data`=C00 in that same cycle.
- Throughput: with `m_ready` held high, one element per cycle, so 4 cycles per result. This is well under the array's minimum of about 12 cycles per result.
- FIFO depth is 2 results. With `m_ready` low, the third complete result overflows.
- All outputs are registered or decoded from registered state only. There is no combinational path from `m_ready` to `m_valid`.

## Test plan
- Single result: A=[[1,2],[3,4]], B=[[5,6],[7,8]]. Drive beats (lo,hi) = (0x36,0x11) then (0xB2,0x23), `m_ready`=1. Expect 0x13, 0x16, 0x2B, 0x32 with `m_idx` 0..3, `m_last` on 0x32, and `result_count`=1.
- Backpressure: same burst with `m_ready` low for 5 cycles. Outputs hold 0x13 / `m_idx`=0 stable; the full stream then follows in order.
- Overflow: three bursts with `m_ready`=0. First two are retained; `overflow`=1 after the third; `result_count`=2. Draining yields the first two results only.
- Framing error: one beat (0x36,0x11), then `res_oe`=0, then a valid two-beat burst. Expect `frame_err`=1, and only the second burst is emitted.
- Full FIFO with simultaneous pop: two results queued, last element of the head being accepted on the same edge a third result completes. Expect no overflow and `result_count`=3.
- Reset/clear: assert `rst` between beats, after which all outputs are 0. Then pulse `clr` after an overflow; `overflow`=0 on the next cycle.
